// File: rtl/rfsoc_config.sv
// Shared configuration constants and state encodings for the ADC capture sequencer.
package rfsoc_config;

    localparam int config_reg_width = 16;
    localparam int DEFAULT_TRIG_GAP = 50;
    localparam int DEFAULT_PHASE    = 2;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_LOAD_RUN,
        SEQ_LOAD_SHIFT,
        SEQ_TRIG,
        SEQ_GAP,
        SEQ_CLR_SHIFT,
        SEQ_DONE
    } adc_seq_state_t;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LEAD,
        SER_BITS,
        SER_TRAIL
    } ser_state_t;

endpackage

// File: rtl/cfg_word_serializer.sv
// Serial framing engine for one config word: a select lead cycle, then per bit
// (LSB first) setup / strobe-high / strobe-low phases, then a select trail cycle.
// The word and target are read live from the caller, which holds them stable
// for the whole word.
module cfg_word_serializer
    import rfsoc_config::*;
#(
    parameter int CFG_W = config_reg_width,
    parameter int PHASE = DEFAULT_PHASE
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             go_i,
    input  logic [CFG_W-1:0] word_i,
    input  logic             target_shift_i,
    output logic             sdata_o,
    output logic [1:0]       strobe_o,
    output logic             select_o,
    output logic             word_done_o
);

    localparam int SUB_N = 3 * PHASE;
    localparam int SUB_W = $clog2(SUB_N);
    localparam int BIT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

    ser_state_t       state_q, state_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             strobe_high;

    // State and phase/bit counters, cleared on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SER_IDLE;
            sub_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sub_q   <= sub_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state: walk lead -> bits -> trail; a go in trail chains straight into the next word
    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        bit_d   = bit_q;
        if (clear_i) begin
            state_d = SER_IDLE;
            sub_d   = '0;
            bit_d   = '0;
        end else begin
            case (state_q)
                SER_IDLE: begin
                    if (go_i) begin
                        state_d = SER_LEAD;
                        sub_d   = '0;
                        bit_d   = '0;
                    end
                end
                SER_LEAD: begin
                    state_d = SER_BITS;
                end
                SER_BITS: begin
                    if (sub_q == SUB_W'(SUB_N - 1)) begin
                        sub_d = '0;
                        if (bit_q == BIT_W'(CFG_W - 1)) begin
                            state_d = SER_TRAIL;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                SER_TRAIL: begin
                    sub_d = '0;
                    bit_d = '0;
                    if (go_i) begin
                        state_d = SER_LEAD;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end
                default: begin
                    state_d = SER_IDLE;
                end
            endcase
        end
    end

    // Output decode: data held across all three phases, strobe only in the middle phase
    always_comb begin
        strobe_high = (state_q == SER_BITS) &&
                      (sub_q >= SUB_W'(PHASE)) && (sub_q < SUB_W'(2 * PHASE));
        sdata_o     = (state_q == SER_BITS) && word_i[bit_q];
        strobe_o    = {strobe_high & target_shift_i, strobe_high & ~target_shift_i};
        select_o    = (state_q != SER_IDLE);
        word_done_o = (state_q == SER_TRAIL);
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Drives the adc_driver GPIO control word from PL: loads run-cycle and shift
// registers serially, fires 2^shift triggers with a fixed gap, then clears the
// shift register so the accumulated result can be read out.
module adc_capture_sequencer
    import rfsoc_config::*;
#(
    parameter int CFG_W     = config_reg_width,
    parameter int MAX_SHIFT = 8,
    parameter int TRIG_GAP  = DEFAULT_TRIG_GAP,
    parameter int PHASE     = DEFAULT_PHASE
) (
    input  logic             ps_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CFG_W-1:0] cfg_run_cycles,
    input  logic [CFG_W-1:0] cfg_shift_val,
    output logic             sdata,
    output logic             run_cycles_clk,
    output logic             shift_val_clk,
    output logic             trigger,
    output logic             select_out,
    output logic             busy,
    output logic             done,
    output logic             readout_ready
);

    localparam int SH_W  = $clog2(MAX_SHIFT + 1);
    localparam int CNT_W = MAX_SHIFT + 1;
    localparam int GAP_W = (TRIG_GAP > 1) ? $clog2(TRIG_GAP) : 1;

    adc_seq_state_t   state_q, state_d;
    logic [CFG_W-1:0] run_q;
    logic [SH_W-1:0]  shift_q;
    logic [CNT_W-1:0] trig_cnt_q;
    logic [GAP_W-1:0] gap_cnt_q;
    logic             ready_q;

    logic             start_ok;
    logic             abort_hit;
    logic [SH_W-1:0]  shift_clamped;
    logic [CNT_W-1:0] trig_total;
    logic             ser_go;
    logic [CFG_W-1:0] ser_word;
    logic             ser_target_shift;
    logic             ser_sdata;
    logic [1:0]       ser_strobe;
    logic             ser_select;
    logic             ser_done;

    assign start_ok      = start && !abort && (state_q == SEQ_IDLE);
    assign abort_hit     = abort && (state_q != SEQ_IDLE);
    assign shift_clamped = (cfg_shift_val > CFG_W'(MAX_SHIFT)) ? SH_W'(MAX_SHIFT)
                                                               : SH_W'(cfg_shift_val);
    assign trig_total    = CNT_W'(1) << shift_q;

    // State register plus latched config, trigger/gap counters and readout flag
    always_ff @(posedge ps_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= SEQ_IDLE;
            run_q      <= '0;
            shift_q    <= '0;
            trig_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (abort_hit) begin
                ready_q <= 1'b0;
            end else if (start_ok) begin
                run_q      <= cfg_run_cycles;
                shift_q    <= shift_clamped;
                trig_cnt_q <= '0;
                gap_cnt_q  <= '0;
                ready_q    <= 1'b0;
            end else begin
                if (state_q == SEQ_TRIG) begin
                    trig_cnt_q <= trig_cnt_q + CNT_W'(1);
                    gap_cnt_q  <= '0;
                end else if (state_q == SEQ_GAP) begin
                    gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                end
                if ((state_q == SEQ_CLR_SHIFT) && (state_d == SEQ_DONE)) begin
                    ready_q <= 1'b1;
                end
            end
        end
    end

    // Next-state sequencing; go is raised on the cycle a load state is entered
    always_comb begin
        state_d = state_q;
        ser_go  = 1'b0;
        if (abort_hit) begin
            state_d = SEQ_IDLE;
        end else begin
            case (state_q)
                SEQ_IDLE: begin
                    if (start_ok) begin
                        state_d = SEQ_LOAD_RUN;
                        ser_go  = 1'b1;
                    end
                end
                SEQ_LOAD_RUN: begin
                    if (ser_done) begin
                        state_d = SEQ_LOAD_SHIFT;
                        ser_go  = 1'b1;
                    end
                end
                SEQ_LOAD_SHIFT: begin
                    if (ser_done) begin
                        state_d = SEQ_TRIG;
                    end
                end
                SEQ_TRIG: begin
                    state_d = SEQ_GAP;
                end
                SEQ_GAP: begin
                    if (gap_cnt_q == GAP_W'(TRIG_GAP - 1)) begin
                        if (trig_cnt_q == trig_total) begin
                            state_d = SEQ_CLR_SHIFT;
                            ser_go  = 1'b1;
                        end else begin
                            state_d = SEQ_TRIG;
                        end
                    end
                end
                SEQ_CLR_SHIFT: begin
                    if (ser_done) begin
                        state_d = SEQ_DONE;
                    end
                end
                SEQ_DONE: begin
                    state_d = SEQ_IDLE;
                end
                default: begin
                    state_d = SEQ_IDLE;
                end
            endcase
        end
    end

    // Word and target presented to the shared serializer for the current load state
    always_comb begin
        ser_word         = '0;
        ser_target_shift = 1'b1;
        case (state_q)
            SEQ_LOAD_RUN: begin
                ser_word         = run_q;
                ser_target_shift = 1'b0;
            end
            SEQ_LOAD_SHIFT: begin
                ser_word = CFG_W'(shift_q);
            end
            default: begin
                ser_word = '0;
            end
        endcase
    end

    cfg_word_serializer #(
        .CFG_W (CFG_W),
        .PHASE (PHASE)
    ) u_serializer (
        .clk_i          (ps_clk),
        .rst_ni         (rst),
        .clear_i        (abort_hit),
        .go_i           (ser_go),
        .word_i         (ser_word),
        .target_shift_i (ser_target_shift),
        .sdata_o        (ser_sdata),
        .strobe_o       (ser_strobe),
        .select_o       (ser_select),
        .word_done_o    (ser_done)
    );

    assign sdata          = ser_sdata;
    assign run_cycles_clk = ser_strobe[0];
    assign shift_val_clk  = ser_strobe[1];
    assign select_out     = ser_select;
    assign trigger        = (state_q == SEQ_TRIG);
    assign done           = (state_q == SEQ_DONE);
    assign busy           = (state_q != SEQ_IDLE);
    assign readout_ready  = ready_q;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Self-checking bench: a trace model expands each accepted start into the full
// expected per-cycle output stream; a compare process checks every cycle, and
// directed tests pin decoded words, trigger counts and spacing with literals.
module tb_adc_capture_sequencer;

    localparam int W        = 16;
    localparam int GAP      = 50;
    localparam int PH       = 2;
    localparam int MAXSHIFT = 8;

    logic          ps_clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [W-1:0]  cfgRun;
    logic [W-1:0]  cfgShift;
    logic          sdata;
    logic          run_cycles_clk;
    logic          shift_val_clk;
    logic          trigger;
    logic          select_out;
    logic          busy;
    logic          done;
    logic          readout_ready;

    int            compCount;
    int            failCount;
    int            cyc;
    bit            chkEn;

    // Expected stream: {sdata, run_clk, shift_clk, trigger, select, busy, done, ready}
    logic [7:0]    expQ[$];
    bit            readyM;
    bit            expBusyNow;

    logic [W-1:0]  runWords[$];
    logic [W-1:0]  shiftWords[$];
    int            trigTimes[$];
    int            doneCount;
    int            lastStartCyc;

    adc_capture_sequencer dut (
        .ps_clk         (ps_clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_run_cycles (cfgRun),
        .cfg_shift_val  (cfgShift),
        .sdata          (sdata),
        .run_cycles_clk (run_cycles_clk),
        .shift_val_clk  (shift_val_clk),
        .trigger        (trigger),
        .select_out     (select_out),
        .busy           (busy),
        .done           (done),
        .readout_ready  (readout_ready)
    );

    initial begin
        ps_clk = 1'b0;
        forever #5 ps_clk = ~ps_clk;
    end

    always @(posedge ps_clk) cyc++;

    function automatic logic [7:0] mkVec(input bit sd, input bit rc, input bit sc, input bit tr,
                                         input bit se, input bit bu, input bit dn, input bit rd);
        return {sd, rc, sc, tr, se, bu, dn, rd};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One serial word: select lead, 16 bits x (setup, high, low) phases, select trail
    task automatic pushWord(input logic [W-1:0] w, input bit isShift);
        expQ.push_back(mkVec(0, 0, 0, 0, 1, 1, 0, 0));
        for (int b = 0; b < W; b++) begin
            for (int p = 0; p < 3 * PH; p++) begin
                bit hi;
                hi = (p >= PH) && (p < 2 * PH);
                expQ.push_back(mkVec(w[b], hi && !isShift, hi && isShift, 0, 1, 1, 0, 0));
            end
        end
        expQ.push_back(mkVec(0, 0, 0, 0, 1, 1, 0, 0));
    endtask

    task automatic pushSequence(input logic [W-1:0] run, input logic [W-1:0] shift);
        int eff;
        eff = (shift > MAXSHIFT) ? MAXSHIFT : int'(shift);
        pushWord(run, 1'b0);
        pushWord(W'(eff), 1'b1);
        for (int k = 0; k < (1 << eff); k++) begin
            expQ.push_back(mkVec(0, 0, 0, 1, 0, 1, 0, 0));
            for (int g = 0; g < GAP; g++) expQ.push_back(mkVec(0, 0, 0, 0, 0, 1, 0, 0));
        end
        pushWord('0, 1'b1);
        expQ.push_back(mkVec(0, 0, 0, 0, 0, 1, 1, 1));
    endtask

    // Per-cycle comparison of every output against the model stream
    always @(negedge ps_clk) begin
        if (chkEn) begin
            logic [7:0] expV;
            logic [7:0] actV;
            if (expQ.size() > 0) expV = expQ.pop_front();
            else                 expV = mkVec(0, 0, 0, 0, 0, 0, 0, readyM);
            if (expV[1]) readyM = 1'b1;
            expBusyNow = expV[2];
            actV = {sdata, run_cycles_clk, shift_val_clk, trigger, select_out, busy, done, readout_ready};
            compCount++;
            if (actV !== expV) begin
                failCount++;
                $display("[TB] FAIL cycle_outputs @cyc %0d: got %b, expected %b", cyc, actV, expV);
            end
        end
    end

    // Observation of strobed words, trigger times and done pulses
    always @(negedge ps_clk) begin
        static int       rBits = 0;
        static int       sBits = 0;
        static logic [W-1:0] rWord = '0;
        static logic [W-1:0] sWord = '0;
        static logic     prevR = 1'b0;
        static logic     prevS = 1'b0;
        if (!rst) begin
            rBits = 0;
            sBits = 0;
        end else begin
            if (run_cycles_clk && !prevR) begin
                rWord[rBits] = sdata;
                rBits++;
                if (rBits == W) begin
                    runWords.push_back(rWord);
                    rBits = 0;
                end
            end
            if (shift_val_clk && !prevS) begin
                sWord[sBits] = sdata;
                sBits++;
                if (sBits == W) begin
                    shiftWords.push_back(sWord);
                    sBits = 0;
                end
            end
            if (trigger) trigTimes.push_back(cyc);
            if (done) doneCount++;
        end
        prevR = run_cycles_clk;
        prevS = shift_val_clk;
    end

    task automatic applyStimulus(input logic [W-1:0] run, input logic [W-1:0] shift, input bit withAbort);
        @(negedge ps_clk);
        #1;
        cfgRun   = run;
        cfgShift = shift;
        start    = 1'b1;
        abort    = withAbort;
        if (rst && !expBusyNow && !withAbort) begin
            pushSequence(run, shift);
            readyM       = 1'b0;
            lastStartCyc = cyc;
        end
        @(negedge ps_clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic applyAbort();
        @(negedge ps_clk);
        #1;
        abort = 1'b1;
        if (rst && expBusyNow) begin
            expQ.delete();
            readyM = 1'b0;
        end
        @(negedge ps_clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (!(expQ.size() == 0 && !expBusyNow && busy == 1'b0) && n < budget) begin
            @(negedge ps_clk);
            #2;
            n++;
        end
        if (n >= budget) begin
            compCount++;
            failCount++;
            $display("[TB] FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    initial begin
        int tb0, sw0, rw0, d0, n;
        compCount = 0; failCount = 0; cyc = 0; chkEn = 0; readyM = 0; expBusyNow = 0;
        doneCount = 0; lastStartCyc = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; cfgRun = '0; cfgShift = '0;
        #1 rst = 1'b0;
        chkEn = 1'b1;

        // Reset hold with a start pulse that must be ignored
        repeat (3) @(negedge ps_clk);
        applyStimulus(16'd5, 16'd2, 1'b0);
        repeat (6) @(negedge ps_clk);
        #1 rst = 1'b1;
        repeat (5) @(negedge ps_clk);
        #1;
        checkOutput("busy_after_reset", busy, 0);
        checkOutput("ready_after_reset", readout_ready, 0);
        checkOutput("trig_after_reset", trigTimes.size(), 0);

        // Nominal run=4, shift=2
        tb0 = trigTimes.size(); sw0 = shiftWords.size(); rw0 = runWords.size(); d0 = doneCount;
        applyStimulus(16'd4, 16'd2, 1'b0);
        waitIdle(2000);
        checkOutput("nominal_trig_count", trigTimes.size() - tb0, 4);
        checkOutput("nominal_first_trig_latency",
                    (trigTimes.size() > tb0) ? trigTimes[tb0] - lastStartCyc : -1, 197);
        for (int k = 1; k < 4; k++)
            checkOutput("nominal_trig_spacing",
                        (trigTimes.size() > tb0 + k) ? trigTimes[tb0 + k] - trigTimes[tb0 + k - 1] : -1, 51);
        checkOutput("nominal_run_word", (runWords.size() > rw0) ? int'(runWords[rw0]) : -1, 4);
        checkOutput("nominal_shift_word", (shiftWords.size() > sw0) ? int'(shiftWords[sw0]) : -1, 2);
        checkOutput("nominal_clr_word", (shiftWords.size() > sw0 + 1) ? int'(shiftWords[sw0 + 1]) : -1, 0);
        checkOutput("nominal_done_pulses", doneCount - d0, 1);
        checkOutput("nominal_ready", readout_ready, 1);

        // Clamp: shift=12 behaves as 8
        tb0 = trigTimes.size(); sw0 = shiftWords.size();
        applyStimulus(16'd9, 16'd12, 1'b0);
        waitIdle(15000);
        checkOutput("clamp_trig_count", trigTimes.size() - tb0, 256);
        checkOutput("clamp_shift_word", (shiftWords.size() > sw0) ? int'(shiftWords[sw0]) : -1, 8);

        // Abort mid-gap after the second trigger
        tb0 = trigTimes.size(); d0 = doneCount;
        applyStimulus(16'd3, 16'd3, 1'b0);
        n = 0;
        while (trigTimes.size() < tb0 + 2 && n < 1000) begin
            @(negedge ps_clk);
            #2;
            n++;
        end
        checkOutput("abort_reached_second_trig", trigTimes.size() - tb0, 2);
        repeat (10) @(negedge ps_clk);
        applyAbort();
        checkOutput("abort_outputs_zero",
                    int'({sdata, run_cycles_clk, shift_val_clk, trigger, select_out, busy, done, readout_ready}), 0);
        repeat (300) @(negedge ps_clk);
        checkOutput("abort_no_more_trigs", trigTimes.size() - tb0, 2);
        checkOutput("abort_no_done", doneCount - d0, 0);

        // Full rerun after abort
        tb0 = trigTimes.size(); d0 = doneCount;
        applyStimulus(16'd5, 16'd1, 1'b0);
        waitIdle(2000);
        checkOutput("rerun_trig_count", trigTimes.size() - tb0, 2);
        checkOutput("rerun_done", doneCount - d0, 1);

        // start during LOAD_SHIFT is ignored
        tb0 = trigTimes.size(); rw0 = runWords.size();
        applyStimulus(16'd2, 16'd1, 1'b0);
        repeat (118) @(negedge ps_clk);
        applyStimulus(16'd7, 16'd5, 1'b0);
        waitIdle(2000);
        checkOutput("busy_start_trig_count", trigTimes.size() - tb0, 2);
        checkOutput("busy_start_run_words", runWords.size() - rw0, 1);

        // Zero shift gives exactly one trigger
        tb0 = trigTimes.size(); sw0 = shiftWords.size();
        applyStimulus(16'd1, 16'd0, 1'b0);
        waitIdle(2000);
        checkOutput("zero_trig_count", trigTimes.size() - tb0, 1);
        checkOutput("zero_shift_word", (shiftWords.size() > sw0) ? int'(shiftWords[sw0]) : -1, 0);

        // Simultaneous start and abort in IDLE: abort wins
        applyStimulus(16'd1, 16'd1, 1'b1);
        repeat (5) @(negedge ps_clk);
        #1;
        checkOutput("start_abort_idle_busy", busy, 0);
        checkOutput("start_abort_idle_ready", readout_ready, 1);

        repeat (3) @(negedge ps_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule

// File: doc/adc_capture_sequencer.md
Name: adc_capture_sequencer

Overview:
PL-side sequencer that replaces software bit-banging of the ADC driver's GPIO control word. On a start command it serially loads the run-cycle and shift-value config registers. It then fires 2^shift triggers separated by a fixed gap, and finally reloads shift = 0 so the accumulated result can be read out. It sits between the control register bank and the adc_driver gpio_ctrl/select_in inputs.

Parameters:
CFG_W, 16, config register width; instantiated with rfsoc_config::config_reg_width
MAX_SHIFT, 8, largest accepted shift value; larger requests are clamped
TRIG_GAP, 50, idle cycles after each trigger pulse
PHASE, 2, cycles per serial phase (setup / clk-high / clk-low)

Ports:
ps_clk  in  1  sole clock
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  synchronous abort; forces IDLE next cycle
cfg_run_cycles  in  CFG_W  capture cycles per trigger
cfg_shift_val  in  CFG_W  log2 of trigger count
sdata  out  1  serial config data
run_cycles_clk  out  1  strobe for the run-cycle register
shift_val_clk  out  1  strobe for the shift-value register
trigger  out  1  ADC trigger pulse
select_out  out  1  drives adc_driver select_in
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at completion
readout_ready  out  1  level; set with done, cleared by the next accepted start or by abort

Behaviour:
- Reset (rst=0): FSM goes to IDLE. All outputs are 0. Counters and latched config are 0.
- Start acceptance: in IDLE, start=1 latches cfg_run_cycles and shift_eff = min(cfg_shift_val, MAX_SHIFT), sets busy, and clears readout_ready. start outside IDLE is ignored.
- FSM sequence: IDLE -> LOAD_RUN -> LOAD_SHIFT -> TRIG -> GAP -> (TRIG, while triggers remain) -> CLR_SHIFT -> DONE -> IDLE.
- Serial word load (LOAD_RUN, LOAD_SHIFT, CLR_SHIFT):
  - select_out rises for 1 cycle before the first bit.
  - Per bit, LSB first: sdata is set and held PHASE cycles; then the target strobe is high for PHASE cycles; then the strobe is low for PHASE cycles. sdata is stable through all 3 phases.
  - select_out stays high for 1 cycle after the last bit, then falls.
  - Word length = 2 + 3*PHASE*CFG_W cycles (98 at defaults).
  - Only the strobe for the word being loaded toggles. sdata returns to 0 between words.
- LOAD_RUN shifts the latched run_cycles word. LOAD_SHIFT shifts shift_eff zero-extended to CFG_W.
- TRIG: trigger is high for exactly 1 cycle. GAP then holds for TRIG_GAP cycles. Trigger period = TRIG_GAP+1.
- Trigger count is exactly 2^shift_eff. shift_eff=0 gives 1 trigger.
- CLR_SHIFT loads 0 into the shift-value register using shift_val_clk.
- DONE lasts 1 cycle: done=1, readout_ready set, busy cleared on the transition back to IDLE.
- Trigger counter width is MAX_SHIFT+1 bits. There is no wrap.
- Abort: from any non-IDLE state, the next cycle is IDLE. All strobes, sdata, trigger, select_out and busy drop to 0, and readout_ready is 0. No done pulse is issued. abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: abort wins and start is dropped.
- Asynchronous reset mid-word: outputs drop immediately. The partially loaded register is undefined to downstream logic; software must re-run.

Decomposition:
- rfsoc_config package holds:
  - config_reg_width
  - the FSM state enum adc_seq_state_t
  - the shared constants DEFAULT_TRIG_GAP and DEFAULT_PHASE
- One sub-module: cfg_word_serializer.
  - Inputs: go, word, target select.
  - Outputs: sdata, strobe, select, word_done.
  - Behaviour: implements the select/setup/high/low framing above.
  - Reuse: instantiated once and shared by the 3 load states.

Test Plan:
- Reset hold: rst=0 for 10 cycles with start pulsed -> all outputs 0, and busy stays 0 after release.
- Nominal run: run=4, shift=2 -> run_cycles_clk shows 16 pulses carrying bits 0,0,1,0,... LSB first, with sdata matching each rising strobe. Then 4 trigger pulses exactly 51 cycles apart, a 16-pulse shift_val_clk word of all zeros, then done for 1 cycle with readout_ready=1.
- Timing check: measure from start to the first trigger at default parameters -> 1 + 98 + 98 cycles, ±1 for the registered state entry; this is locked in the bench.
- Clamp: shift=12 -> exactly 256 triggers, and the LOAD_SHIFT word decodes to 8.
- Abort mid-GAP after the 2nd trigger -> the next cycle has all outputs 0, no done pulse and no further triggers. A new start then runs the full sequence.
- start while busy (pulsed during LOAD_SHIFT) -> ignored, trigger count unchanged. Zero case: shift=0 -> exactly 1 trigger.
